index_reg_bank: RTL and testbench
=================================

# index_reg_bank

Parametrised, clocked successor to the single latched index register: a bank of NUM_REGS index registers (X, Y by default) sharing one system-bus port. Each register can be loaded from the bus, driven onto the bus, incremented, decremented or copied to another register. Every register update produces registered N/Z flags for the status unit. The block sits beside the ALU on the MOS 6502 internal data bus and serves INX/INY/DEX/DEY, LDX/LDY, STX/STY and TAX-style transfers.

## Interface
Parameters:
- WIDTH, 8, bit width of each register and of the bus.
- NUM_REGS, 2, number of registers; index 0 = X, index 1 = Y; legal range 1..16.
- RESET_VAL, 0, value loaded into every register on reset.

Ports:
- clk  in  1  system clock; all state changes on the rising edge.
- reset_N  in  1  asynchronous, active-low reset.
- systemBus_IN  in  WIDTH  bus data to load.
- systemBusRead_EN  in  1  load the selected register from systemBus_IN.
- systemBusWrite_EN  in  1  drive the selected register onto systemBus_OUT.
- regSelect_IN  in  max(1,$clog2(NUM_REGS))  register addressed by bus read/write and by inc/dec.
- inc_EN  in  1  increment the selected register.
- dec_EN  in  1  decrement the selected register.
- transfer_EN  in  1  copy register transferSrc_IN into register transferDst_IN.
- transferSrc_IN, transferDst_IN  in  same width as regSelect_IN  transfer operands.
- systemBus_OUT  out  WIDTH  bus drive, pulled weak-high as (strong0, weak1); all ones when idle.
- negative_OUT  out  1  MSB of the last written value.
- zero_OUT  out  1  last written value == 0.
- flagsUpdate_OUT  out  1  one-cycle pulse; flags changed this cycle.
- regAll_OUT  out  NUM_REGS*WIDTH  flattened register contents for debug; reg i occupies bits [i*WIDTH +: WIDTH].

## Operation
- Update sources, in priority order (one register write per cycle): bus load > transfer > inc/dec.
- Bus load: reg[regSelect_IN] <= systemBus_IN.
- Transfer: reg[transferDst_IN] <= reg[transferSrc_IN], using the pre-edge value.
- Inc/dec: reg[sel] <= reg[sel] ± 1, modulo 2^WIDTH; wrap all-ones -> 0 and 0 -> all-ones; no carry output.
- inc_EN and dec_EN asserted together: neither executes, and no flag update occurs.
- A lower-priority request that loses arbitration is dropped, not queued.
- Flags: on every executed write, negative_OUT <= new[WIDTH-1] and zero_OUT <= (new == 0), and flagsUpdate_OUT pulses high for one cycle. Flags hold otherwise.
- Transfer with src == dst: register value unchanged, but flags still update from that value.
- Bus drive (combinational): while systemBusWrite_EN is high, systemBus_OUT = reg[regSelect_IN] (current, pre-edge value); otherwise all ones.
- Simultaneous systemBusRead_EN and systemBusWrite_EN on the same register: the output shows the old value, and the new value is stored at the edge.
- Out-of-range select (index ≥ NUM_REGS, including transfer operands): the write is ignored, no flag pulse, and the bus drive is all ones.

## Timing
- Reset (reset_N low, asynchronous assert):
  - all registers = RESET_VAL;
  - negative_OUT = RESET_VAL[WIDTH-1];
  - zero_OUT = (RESET_VAL == 0);
  - flagsUpdate_OUT = 0.
- Reset deassertion is synchronous to clk (external synchroniser); the first edge after release may execute an operation.
- Reset asserted mid-operation aborts it; no partial update survives.
- Write latency: 1 cycle. New value is visible on regAll_OUT, on systemBus_OUT and on the flags after the rising edge that samples the enable.
- Back-to-back operations on the same register every cycle are supported, e.g. inc then inc yields +2 after 2 edges.
- systemBus_OUT has zero-cycle combinational latency from systemBusWrite_EN / regSelect_IN; there is no clock path.
- flagsUpdate_OUT is high exactly in the cycle following an executed write.

## Test plan
- Reset with RESET_VAL=0 -> regAll_OUT=0, zero_OUT=1, negative_OUT=0, flagsUpdate_OUT=0, systemBus_OUT=8'hFF.
- Load X=8'h7F, then inc_EN on X -> X=8'h80, negative_OUT=1, zero_OUT=0, flagsUpdate_OUT pulses once; inc again from 8'hFF -> 8'h00, zero_OUT=1.
- Load Y=8'h00, then dec_EN -> Y=8'hFF, negative_OUT=1; inc_EN and dec_EN together -> Y unchanged and no flagsUpdate_OUT.
- X=8'h12, Y=8'h34; same cycle assert systemBusRead_EN on X with bus 8'h56 and transfer Y->X -> X=8'h56 (load wins), Y=8'h34.
- systemBusWrite_EN and systemBusRead_EN on X together (X=8'hA5, bus in 8'h3C) -> systemBus_OUT=8'hA5 that cycle, X=8'h3C after the edge.
- NUM_REGS=3, regSelect_IN=3 with load 8'h99 -> no register changes, no flag pulse, systemBus_OUT=8'hFF; assert reset_N low mid-sequence -> all registers return to RESET_VAL immediately.

Source files
------------

// File: rtl/index_reg_bank.sv
// Bank of NUM_REGS index registers sharing one system-bus port, with inc/dec,
// register-to-register transfer and registered N/Z flags for the status unit.
module index_reg_bank #(
    parameter int                 WIDTH     = 8,
    parameter int                 NUM_REGS  = 2,
    parameter logic [WIDTH-1:0]   RESET_VAL = '0,
    localparam int                SEL_W     = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1
) (
    input  logic                      clk,
    input  logic                      reset_N,
    input  logic [WIDTH-1:0]          systemBus_IN,
    input  logic                      systemBusRead_EN,
    input  logic                      systemBusWrite_EN,
    input  logic [SEL_W-1:0]          regSelect_IN,
    input  logic                      inc_EN,
    input  logic                      dec_EN,
    input  logic                      transfer_EN,
    input  logic [SEL_W-1:0]          transferSrc_IN,
    input  logic [SEL_W-1:0]          transferDst_IN,
    output logic [WIDTH-1:0]          systemBus_OUT,
    output logic                      negative_OUT,
    output logic                      zero_OUT,
    output logic                      flagsUpdate_OUT,
    output logic [NUM_REGS*WIDTH-1:0] regAll_OUT
);

    logic [NUM_REGS-1:0][WIDTH-1:0] regs;
    logic [WIDTH-1:0]               sel_val, src_val, wr_val;
    logic [SEL_W-1:0]               wr_idx;
    logic                           sel_ok, src_ok, dst_ok, wr_en;

    assign sel_ok = int'(regSelect_IN)   < NUM_REGS;
    assign src_ok = int'(transferSrc_IN) < NUM_REGS;
    assign dst_ok = int'(transferDst_IN) < NUM_REGS;

    // Out-of-range selects read as all ones, which is also the idle bus level.
    always_comb begin
        sel_val = '1;
        src_val = '1;
        for (int i = 0; i < NUM_REGS; i++) begin
            if (regSelect_IN == SEL_W'(i))   sel_val = regs[i];
            if (transferSrc_IN == SEL_W'(i)) src_val = regs[i];
        end
    end

    // Single write port: bus load beats transfer beats inc/dec. A winning
    // request with a bad index still blocks the lower ones.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = regSelect_IN;
        wr_val = systemBus_IN;
        if (systemBusRead_EN) begin
            wr_en = sel_ok;
        end else if (transfer_EN) begin
            wr_en  = src_ok && dst_ok;
            wr_idx = transferDst_IN;
            wr_val = src_val;
        end else if (inc_EN != dec_EN) begin
            wr_en  = sel_ok;
            wr_val = inc_EN ? sel_val + WIDTH'(1) : sel_val - WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            regs            <= {NUM_REGS{RESET_VAL}};
            negative_OUT    <= RESET_VAL[WIDTH-1];
            zero_OUT        <= (RESET_VAL == '0);
            flagsUpdate_OUT <= 1'b0;
        end else begin
            flagsUpdate_OUT <= wr_en;
            if (wr_en) begin
                regs[wr_idx] <= wr_val;
                negative_OUT <= wr_val[WIDTH-1];
                zero_OUT     <= (wr_val == '0);
            end
        end
    end

    assign systemBus_OUT = systemBusWrite_EN ? sel_val : '1;
    assign regAll_OUT    = regs;

endmodule

// File: tb/tb_index_reg_bank.sv
// Directed bench for index_reg_bank (3 registers) with a per-cycle reference model.
module tb_index_reg_bank;
    localparam int W = 8;
    localparam int N = 3;

    logic         clk = 1'b0;
    logic         reset_N = 1'b0;
    logic [W-1:0] bus_in = '0;
    logic         rd_en = 1'b0, wr_en = 1'b0, inc = 1'b0, dec = 1'b0, tr = 1'b0;
    logic [1:0]   sel = '0, src = '0, dst = '0;
    logic [W-1:0] bus_out;
    logic         neg, zero, upd;
    logic [N*W-1:0] all;

    index_reg_bank #(.WIDTH(W), .NUM_REGS(N), .RESET_VAL('0)) dut (
        .clk(clk), .reset_N(reset_N), .systemBus_IN(bus_in),
        .systemBusRead_EN(rd_en), .systemBusWrite_EN(wr_en), .regSelect_IN(sel),
        .inc_EN(inc), .dec_EN(dec), .transfer_EN(tr),
        .transferSrc_IN(src), .transferDst_IN(dst),
        .systemBus_OUT(bus_out), .negative_OUT(neg), .zero_OUT(zero),
        .flagsUpdate_OUT(upd), .regAll_OUT(all)
    );

    always #5 clk = ~clk;

    int n_chk = 0, n_pass = 0;
    bit chk_on = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: plain integers, one write per edge by priority.
    int m_reg[N];
    int m_neg = 0, m_zero = 1, m_upd = 0;

    always @(posedge clk or negedge reset_N) begin
        if (!reset_N) begin
            for (int i = 0; i < N; i++) m_reg[i] = 0;
            m_neg = 0; m_zero = 1; m_upd = 0;
        end else begin
            int d, v;
            d = -1; v = 0;
            if (rd_en) begin
                if (sel < N) begin d = sel; v = bus_in; end
            end else if (tr) begin
                if (src < N && dst < N) begin d = dst; v = m_reg[src]; end
            end else if (inc && !dec) begin
                if (sel < N) begin d = sel; v = (m_reg[sel] + 1) % 256; end
            end else if (dec && !inc) begin
                if (sel < N) begin d = sel; v = (m_reg[sel] + 255) % 256; end
            end
            m_upd = (d >= 0);
            if (d >= 0) begin
                m_reg[d] = v;
                m_neg = (v >= 128);
                m_zero = (v == 0);
            end
        end
    end

    always @(negedge clk) begin
        if (chk_on) begin
            for (int i = 0; i < N; i++) check($sformatf("model_reg%0d", i), all[i*W +: W], m_reg[i]);
            check("model_neg", neg, m_neg);
            check("model_zero", zero, m_zero);
            check("model_upd", upd, m_upd);
            check("model_bus", bus_out, (wr_en && sel < N) ? m_reg[sel] : 255);
        end
    end

    task automatic idle();
        rd_en = 0; wr_en = 0; inc = 0; dec = 0; tr = 0;
    endtask

    task automatic step();
        @(posedge clk); #1;
        idle();
    endtask

    task automatic load(input logic [1:0] r, input logic [7:0] v);
        sel = r; bus_in = v; rd_en = 1; step();
    endtask

    function automatic logic [7:0] rg(input int i);
        return all[i*W +: W];
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        check("rst_all", all, 0);
        check("rst_zero", zero, 1);
        check("rst_neg", neg, 0);
        check("rst_upd", upd, 0);
        check("rst_bus", bus_out, 8'hFF);
        reset_N = 1; chk_on = 1;

        load(0, 8'h7F);
        check("ld_x", rg(0), 8'h7F);
        sel = 0; inc = 1; step();
        check("inc_x", rg(0), 8'h80);
        check("inc_neg", neg, 1);
        check("inc_zero", zero, 0);
        check("inc_upd", upd, 1);
        step();
        check("upd_once", upd, 0);
        load(0, 8'hFF);
        sel = 0; inc = 1; step();
        check("wrap_x", rg(0), 8'h00);
        check("wrap_zero", zero, 1);

        load(1, 8'h00);
        sel = 1; dec = 1; step();
        check("dec_y", rg(1), 8'hFF);
        check("dec_neg", neg, 1);
        sel = 1; inc = 1; dec = 1; step();
        check("incdec_y", rg(1), 8'hFF);
        check("incdec_upd", upd, 0);

        load(0, 8'h12);
        load(1, 8'h34);
        sel = 0; bus_in = 8'h56; rd_en = 1; tr = 1; src = 1; dst = 0; step();
        check("prio_x", rg(0), 8'h56);
        check("prio_y", rg(1), 8'h34);

        load(0, 8'hA5);
        sel = 0; bus_in = 8'h3C; rd_en = 1; wr_en = 1; #1;
        check("rw_bus_old", bus_out, 8'hA5);
        step();
        check("rw_x_new", rg(0), 8'h3C);

        sel = 3; bus_in = 8'h99; rd_en = 1; wr_en = 1; #1;
        check("oor_bus", bus_out, 8'hFF);
        step();
        check("oor_regs", all, {8'h00, 8'h34, 8'h3C});
        check("oor_upd", upd, 0);

        tr = 1; src = 0; dst = 0; step();
        check("self_tr_x", rg(0), 8'h3C);
        check("self_tr_upd", upd, 1);
        tr = 1; src = 1; dst = 2; step();
        check("tr_y_to_r2", rg(2), 8'h34);
        tr = 1; src = 0; dst = 3; step();
        check("tr_oor_upd", upd, 0);

        sel = 2; dec = 1; step();
        sel = 2; dec = 1; step();
        check("b2b_dec", rg(2), 8'h32);

        sel = 0; inc = 1;
        @(posedge clk); #2;
        reset_N = 0; #1;
        check("async_rst_all", all, 0);
        check("async_rst_upd", upd, 0);
        check("async_rst_zero", zero, 1);
        idle();
        @(posedge clk); #1;
        reset_N = 1;
        step();
        check("post_rst_all", all, 0);

        chk_on = 0;
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
